gearbox_pair_arbiter: RTL and testbench

Shares one 1-to-2 width-packing datapath between two upstream requesters. It arbitrates round-robin at pair boundaries and locks the grant until the owner's second word is accepted, so a packed output word never mixes data from both requesters. It sits between two narrow producers and a single double-width consumer. The consumer sees packed words tagged with the source requester.

---
 rtl/gearbox_pair_arbiter.sv | 171 +++++++++++++++++
 tb/tb_gearbox_pair_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gearbox_pair_arbiter.sv
// gearbox_pair_arbiter
// Two narrow requesters share one 1-to-2 width packer. A requester that gets
// its first word accepted owns the packer until its second word is accepted,
// so every packed output word carries data from exactly one requester.
// Contested grants in the empty state are round-robin by default.
// Build option: define GEARBOX_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins a contested grant); the pair lock still applies.
module gearbox_pair_arbiter #(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up0_vld,
  output logic                 up0_rdy,
  input  logic [width-1:0]     up0_data,
  input  logic                 up1_vld,
  output logic                 up1_rdy,
  input  logic [width-1:0]     up1_data,
  output logic                 down_vld,
  input  logic                 down_rdy,
  output logic [2*width-1:0]   down_data,
  output logic                 down_id
);

  // Pair state: EMPTY = no half word held, HALF = first word held, owner locked.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]           state_r;
  logic                 owner_r;
  logic [width-1:0]     half_r;
  logic                 down_vld_r;
  logic [2*width-1:0]   down_data_r;
  logic                 down_id_r;

  logic                 contest_pick_s;
  logic                 grant_vld_s;
  logic                 grant_id_s;
  logic                 out_room_s;
  logic                 rdy0_s;
  logic                 rdy1_s;
  logic                 acc0_s;
  logic                 acc1_s;
  logic                 acc_any_s;
  logic                 first_acc_s;
  logic                 second_acc_s;
  logic [width-1:0]     word_s;

`ifdef GEARBOX_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever both ask at once.
  assign contest_pick_s = 1'b0;
`else
  // Requester most recently granted a first word; reset to 1 so requester 0
  // wins the very first contested grant.
  logic rr_last_r;

  // Round-robin history, updated only when a new pair starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= 1'b1;
    end else if (first_acc_s) begin
      rr_last_r <= acc1_s;
    end
  end

  // A contested grant goes to whichever requester was not granted last.
  assign contest_pick_s = ~rr_last_r;
`endif

  // The output register can take a new word if it is empty or draining now.
  assign out_room_s = ~down_vld_r | down_rdy;

  // Choose which requester may start a new pair (meaningful in EMPTY only).
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (up0_vld && up1_vld) begin
      grant_vld_s = 1'b1;
      grant_id_s  = contest_pick_s;
    end else if (up0_vld) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (up1_vld) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Ready generation: free grant in EMPTY, owner-only (and output room) in HALF.
  always_comb begin
    rdy0_s = 1'b0;
    rdy1_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        rdy0_s = grant_vld_s & ~grant_id_s;
        rdy1_s = grant_vld_s &  grant_id_s;
      end
      ST_HALF: begin
        rdy0_s = out_room_s & ~owner_r;
        rdy1_s = out_room_s &  owner_r;
      end
      default: begin
        rdy0_s = 1'b0;
        rdy1_s = 1'b0;
      end
    endcase
  end

  assign up0_rdy = rdy0_s;
  assign up1_rdy = rdy1_s;

  // At most one requester is ready in any cycle, so accepts are exclusive.
  assign acc0_s       = up0_vld & rdy0_s;
  assign acc1_s       = up1_vld & rdy1_s;
  assign acc_any_s    = acc0_s | acc1_s;
  assign first_acc_s  = acc_any_s & (state_r == ST_EMPTY);
  assign second_acc_s = acc_any_s & (state_r == ST_HALF);
  assign word_s       = acc1_s ? up1_data : up0_data;

  // Pair state machine: capture the first word and lock the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      owner_r <= 1'b0;
      half_r  <= {width{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (first_acc_s) begin
            half_r  <= word_s;
            owner_r <= acc1_s;
            state_r <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (second_acc_s) begin
            state_r <= ST_EMPTY;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Output register: load a completed pair, otherwise drain on down_rdy.
  // A second word is only accepted when there is room, so a stalled word
  // is never overwritten; data and id hold while the register is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_vld_r  <= 1'b0;
      down_data_r <= {(2*width){1'b0}};
      down_id_r   <= 1'b0;
    end else if (second_acc_s) begin
      down_vld_r  <= 1'b1;
      down_data_r <= {half_r, word_s};
      down_id_r   <= owner_r;
    end else if (down_rdy) begin
      down_vld_r  <= 1'b0;
    end
  end

  assign down_vld  = down_vld_r;
  assign down_data = down_data_r;
  assign down_id   = down_id_r;

endmodule

// File: tb/tb_gearbox_pair_arbiter.sv
// Self-checking bench for gearbox_pair_arbiter: directed scenarios followed by
// random traffic, all compared against a pair-level reference model.
module tb_gearbox_pair_arbiter;

  localparam int W = 8;
`ifdef GEARBOX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           up0_vld = 1'b0;
  logic           up0_rdy;
  logic [W-1:0]   up0_data = '0;
  logic           up1_vld = 1'b0;
  logic           up1_rdy;
  logic [W-1:0]   up1_data = '0;
  logic           down_vld;
  logic           down_rdy = 1'b0;
  logic [2*W-1:0] down_data;
  logic           down_id;

  gearbox_pair_arbiter #(.width(W)) dut (
    .clk(clk), .rst(rst),
    .up0_vld(up0_vld), .up0_rdy(up0_rdy), .up0_data(up0_data),
    .up1_vld(up1_vld), .up1_rdy(up1_rdy), .up1_data(up1_data),
    .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data),
    .down_id(down_id)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: which requester holds a half pair, what is waiting
  // in the output slot, and who started the most recent pair.
  bit         holding_m;
  bit         owner_m;
  logic [7:0] half_m;
  bit         last_first_m;
  bit         slot_full_m;
  logic [15:0] slot_data_m;
  bit         slot_id_m;
  bit         exp_rdy0, exp_rdy1;
  bit         new_word_m;
  bit         acc0_m, acc1_m;
  logic       seen_rdy0, seen_rdy1;
  int         ids_seen [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    holding_m    = 1'b0;
    owner_m      = 1'b0;
    half_m       = 8'h00;
    last_first_m = 1'b1;
    slot_full_m  = 1'b0;
    slot_data_m  = 16'h0000;
    slot_id_m    = 1'b0;
  endtask

  // Who may transfer this cycle, from the arbitration and pair-lock rules.
  task automatic model_predict(input bit v0, input bit v1, input bit dr);
    int winner;
    winner = -1;
    if (!holding_m) begin
      if (v0 && v1) winner = FIXED ? 0 : (last_first_m ? 0 : 1);
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
      exp_rdy0 = (winner == 0);
      exp_rdy1 = (winner == 1);
    end else begin
      exp_rdy0 = (owner_m == 1'b0) && (!slot_full_m || dr);
      exp_rdy1 = (owner_m == 1'b1) && (!slot_full_m || dr);
    end
  endtask

  // Apply one clock edge to the model.
  task automatic model_advance(input bit v0, input logic [7:0] d0,
                               input bit v1, input logic [7:0] d1, input bit dr);
    logic [7:0] w;
    acc0_m     = v0 && exp_rdy0;
    acc1_m     = v1 && exp_rdy1;
    w          = acc1_m ? d1 : d0;
    new_word_m = 1'b0;
    if (acc0_m || acc1_m) begin
      if (!holding_m) begin
        holding_m    = 1'b1;
        owner_m      = acc1_m;
        half_m       = w;
        last_first_m = acc1_m;
      end else begin
        holding_m   = 1'b0;
        new_word_m  = 1'b1;
        slot_full_m = 1'b1;
        slot_data_m = {half_m, w};
        slot_id_m   = owner_m;
      end
    end
    if (!new_word_m && dr) slot_full_m = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check readies, clock, check outputs.
  task automatic cycle(input bit v0, input logic [7:0] d0,
                       input bit v1, input logic [7:0] d1, input bit dr);
    @(negedge clk);
    up0_vld = v0; up0_data = d0;
    up1_vld = v1; up1_data = d1;
    down_rdy = dr;
    #1;
    model_predict(v0, v1, dr);
    seen_rdy0 = up0_rdy;
    seen_rdy1 = up1_rdy;
    chk("up0_rdy", {31'd0, up0_rdy}, {31'd0, exp_rdy0});
    chk("up1_rdy", {31'd0, up1_rdy}, {31'd0, exp_rdy1});
    @(posedge clk);
    model_advance(v0, d0, v1, d1, dr);
    #1;
    chk("down_vld", {31'd0, down_vld}, {31'd0, slot_full_m});
    if (slot_full_m) begin
      chk("down_data", {16'd0, down_data}, {16'd0, slot_data_m});
      chk("down_id", {31'd0, down_id}, {31'd0, slot_id_m});
    end
    if (new_word_m) ids_seen[down_id]++;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_down_vld", {31'd0, down_vld}, 32'd0);
    up0_vld = 1'b0; up1_vld = 1'b0; down_rdy = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_down_data", {16'd0, down_data}, 32'd0);
    chk("rst_down_id", {31'd0, down_id}, 32'd0);
  endtask

  initial begin
    logic [7:0] n0, n1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_down_vld", {31'd0, down_vld}, 32'd0);
    chk("reset_down_data", {16'd0, down_data}, 32'd0);
    chk("reset_down_id", {31'd0, down_id}, 32'd0);

    // Reset mid-pair with a full output register.
    cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h78, 1'b0, 8'h00, 1'b0);
    chk("full_before_rst", {16'd0, down_data}, 32'h7778);
    cycle(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
    chk("first_word_while_full", {31'd0, seen_rdy0}, 32'd1);
    async_reset();
    cycle(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    chk("post_rst_data", {16'd0, down_data}, 32'h2233);
    chk("post_rst_id", {31'd0, down_id}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Single requester streaming.
    cycle(1'b1, 8'hA1, 1'b0, 8'h00, 1'b1);
    chk("stream_rdy_a1", {31'd0, seen_rdy0}, 32'd1);
    cycle(1'b1, 8'hA2, 1'b0, 8'h00, 1'b1);
    chk("stream_rdy_a2", {31'd0, seen_rdy0}, 32'd1);
    chk("stream_word1", {16'd0, down_data}, 32'hA1A2);
    cycle(1'b1, 8'hA3, 1'b0, 8'h00, 1'b1);
    chk("stream_rdy_a3", {31'd0, seen_rdy0}, 32'd1);
    chk("stream_gap_vld", {31'd0, down_vld}, 32'd0);
    cycle(1'b1, 8'hA4, 1'b0, 8'h00, 1'b1);
    chk("stream_rdy_a4", {31'd0, seen_rdy0}, 32'd1);
    chk("stream_word2", {16'd0, down_data}, 32'hA3A4);
    chk("stream_id", {31'd0, down_id}, 32'd0);

    // Contention from reset.
    async_reset();
    n0 = 8'h00; n1 = 8'h10;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, n0, 1'b1, n1, 1'b1);
      if (acc0_m) n0 = n0 + 8'd1;
      if (acc1_m) n1 = n1 + 8'd1;
      if (i == 1) chk("cont_pair1", {16'd0, down_data}, 32'h0001);
      if (i == 3) chk("cont_pair2", {16'd0, down_data}, FIXED ? 32'h0203 : 32'h1011);
      if (i == 5) chk("cont_pair3", {16'd0, down_data}, FIXED ? 32'h0405 : 32'h0203);
    end

    // Pair lock, then backpressure on the next owner.
    async_reset();
    cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 8'h99, 1'b1);
      chk("lock_up1_rdy", {31'd0, seen_rdy1}, 32'd0);
    end
    cycle(1'b1, 8'h66, 1'b1, 8'h99, 1'b0);
    chk("lock_up1_rdy_last", {31'd0, seen_rdy1}, 32'd0);
    chk("lock_data", {16'd0, down_data}, 32'h5566);
    chk("lock_id", {31'd0, down_id}, 32'd0);
    cycle(!FIXED, 8'h77, 1'b1, 8'h99, 1'b0);
    chk("next_grant_r1", {31'd0, seen_rdy1}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 8'h77, 1'b1, 8'h9A, 1'b0);
      chk("bp_up1_rdy", {31'd0, seen_rdy1}, 32'd0);
      chk("bp_up0_rdy", {31'd0, seen_rdy0}, 32'd0);
      chk("bp_hold", {16'd0, down_data}, 32'h5566);
    end
    cycle(1'b1, 8'h77, 1'b1, 8'h9A, 1'b1);
    chk("bp_release_rdy", {31'd0, seen_rdy1}, 32'd1);
    chk("bp_reload_vld", {31'd0, down_vld}, 32'd1);
    chk("bp_reload_data", {16'd0, down_data}, 32'h999A);
    chk("bp_reload_id", {31'd0, down_id}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random traffic against the model.
    async_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    // Fairness with both requesters always valid.
    async_reset();
    ids_seen[0] = 0;
    ids_seen[1] = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b1);
    end
    chk("fair_id0_pairs", ids_seen[0], FIXED ? 32'd20 : 32'd10);
    chk("fair_id1_pairs", ids_seen[1], FIXED ? 32'd0 : 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
